tile_draw_scheduler: RTL
========================

# tile_draw_scheduler

Sequences the digit-glyph drawing datapath across the 4x4 sliding-puzzle board. On a redraw request it walks all 16 tile slots, fetches each slot's tile value from the board-state store, and for every non-empty slot restarts the glyph datapath, drives the tile's pixel origin and digit select, and enables drawing for one full glyph sweep. It sits between the game FSM (start/done handshake) and the glyph datapath feeding the VGA adapter (x/y/plot).

## Interface

Parameters:
- BOARD_X, 8'd20, pixel x of slot 0's top-left corner
- BOARD_Y, 7'd0, pixel y of slot 0's top-left corner
- TILE_PITCH, 30, pixel spacing between adjacent slots (both axes)
- GLYPH_CYCLES, 101, cycles one full glyph sweep needs with enable high

Ports:
- clk  in  1  system clock; all state changes on rising edge
- resetn  in  1  asynchronous, active-low reset
- start  in  1  redraw request; sampled only in IDLE
- tile_value  in  4  board-store read data; valid the cycle after tile_addr is driven (1-cycle synchronous read); 0 = empty slot
- tile_addr  out  4  board-store read address = current slot
- glyph_sel  out  4  digit to draw (registered copy of tile_value)
- glyph_enable  out  1  enable to glyph datapath
- glyph_resetn  out  1  synchronous active-low restart to glyph datapath
- x_origin  out  8  pixel x of current slot
- y_origin  out  7  pixel y of current slot
- plot  out  1  VGA write enable
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the board sweep completes

## Operation

- Slot s in 0..15: col = s[1:0], row = s[3:2]; x_origin = BOARD_X + col*TILE_PITCH (8-bit), y_origin = BOARD_Y + row*TILE_PITCH (7-bit, truncated). Defaults give max 110/90; no overflow.
- States and transitions:
  - IDLE: start=1 -> FETCH with slot=0; start=0 stays.
  - FETCH: tile_addr=slot -> LATCH.
  - LATCH: register tile_value into glyph_sel; value 0 -> NEXT, else -> CLEAR.
  - CLEAR: glyph_resetn=0 for exactly this cycle; cnt<=0 -> DRAW.
  - DRAW: glyph_enable=1, plot=1; cnt increments; at cnt==GLYPH_CYCLES-1 -> NEXT.
  - NEXT: slot==15 -> DONE; else slot<=slot+1 -> FETCH.
  - DONE: done=1 -> IDLE.
- glyph_enable and plot are high only in DRAW; glyph_resetn is low only in CLEAR (and is 1 otherwise, including reset).
- glyph_sel holds its last value outside LATCH; x_origin/y_origin track slot combinationally.
- start outside IDLE (including during DONE) is ignored, not queued.
- tile_value > 9 is passed through unchanged; decoding is the datapath's concern.

## Timing

- Reset values: state IDLE, slot 0, cnt 0, glyph_sel 0, tile_addr 0, glyph_enable 0, plot 0, glyph_resetn 1, busy 0, done 0, x_origin BOARD_X, y_origin BOARD_Y.
- Asynchronous reset mid-sweep: all outputs return to reset values immediately; plot drops without completing the glyph; no done pulse.
- Cycle cost: empty slot 3 (FETCH, LATCH, NEXT); non-empty slot GLYPH_CYCLES+4 = 105.
- Counting the first cycle after the start-accepting edge as cycle 1: done is high in cycle (sum of slot costs)+1; busy rises in cycle 1 and falls the cycle after done.
- plot is high for exactly GLYPH_CYCLES consecutive cycles per non-empty slot, never across slot boundaries.

## Test plan

- Reset: hold resetn=0 with start=1 -> all outputs at reset values, busy 0; release resetn, start=1 -> busy 1 next cycle, tile_addr=0.
- All slots empty (tile_value always 0): start -> plot never high, done high in cycle 49, busy low in cycle 50.
- Slots 0..14 = 1..15, slot 15 = 0: done in cycle 1579; 15 plot bursts of 101 cycles; slot 5 burst has x_origin=50, y_origin=30, glyph_sel=6; glyph_resetn low exactly one cycle before each burst.
- Only slot 15 = 5: single burst with x_origin=110, y_origin=90, glyph_sel=5; done in cycle 151.
- start pulsed during DRAW and during DONE -> ignored; exactly one done pulse; IDLE afterwards until next start.
- Assert resetn=0 mid-burst at slot 3 -> plot and busy drop asynchronously, no done; next start redraws from slot 0.

Source files
------------

// File: rtl/tile_draw_scheduler.sv
// rtl/tile_draw_scheduler.sv - board redraw sequencer for the digit-glyph datapath
//
// Walks the 16 slots of the 4x4 board on each redraw request. For every slot it
// reads the tile value from the board store. Empty slots (value 0) are skipped.
// Each non-empty slot gets a one-cycle glyph restart and then one full glyph
// sweep with drawing enabled.
//
// Ports:
//   clk, resetn    clock, asynchronous active-low reset
//   start          redraw request, only looked at while idle
//   tile_value     board-store read data, valid one cycle after tile_addr
//   tile_addr      board-store read address (current slot)
//   glyph_sel      digit for the glyph datapath, latched from tile_value
//   glyph_enable   glyph datapath step enable
//   glyph_resetn   glyph datapath synchronous restart, active low
//   x_origin       pixel x of the current slot's top-left corner
//   y_origin       pixel y of the current slot's top-left corner
//   plot           VGA write enable
//   busy           high whenever a sweep is in progress
//   done           one-cycle pulse at the end of a sweep

module tile_draw_scheduler #(
  parameter logic [7:0] BOARD_X      = 8'd20,
  parameter logic [6:0] BOARD_Y      = 7'd0,
  parameter int         TILE_PITCH   = 30,
  parameter int         GLYPH_CYCLES = 101
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] tile_value,
  output logic [3:0] tile_addr,
  output logic [3:0] glyph_sel,
  output logic       glyph_enable,
  output logic       glyph_resetn,
  output logic [7:0] x_origin,
  output logic [6:0] y_origin,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int CntW = $clog2(GLYPH_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(GLYPH_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    CLEAR,
    DRAW,
    NEXT,
    DONE
  } state_t;

  state_t          state;
  logic [3:0]      slot;
  logic [CntW-1:0] cnt;

  // The read address is simply the slot. It is held stable from FETCH through
  // LATCH, so the synchronous board store has a full cycle to return data.
  assign tile_addr = slot;

  // Slot origin: col = slot[1:0], row = slot[3:2]. The sums are truncated to
  // the width of each port.
  assign x_origin = BOARD_X + 8'(32'(slot[1:0]) * TILE_PITCH);
  assign y_origin = BOARD_Y + 7'(32'(slot[3:2]) * TILE_PITCH);

  // The datapath controls are registered. Each one is set on the edge that
  // enters the state that owns it. That makes it line up exactly with that
  // state, and reset forces it back immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      slot         <= 4'd0;
      cnt          <= '0;
      glyph_sel    <= 4'd0;
      glyph_enable <= 1'b0;
      glyph_resetn <= 1'b1;
      plot         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            slot  <= 4'd0;
            busy  <= 1'b1;
          end
        end

        FETCH: begin
          state <= LATCH;
        end

        LATCH: begin
          glyph_sel <= tile_value;
          if (tile_value == 4'd0) begin
            state <= NEXT;
          end else begin
            state        <= CLEAR;
            glyph_resetn <= 1'b0;
          end
        end

        CLEAR: begin
          state        <= DRAW;
          cnt          <= '0;
          glyph_resetn <= 1'b1;
          glyph_enable <= 1'b1;
          plot         <= 1'b1;
        end

        DRAW: begin
          cnt <= cnt + CntW'(1);
          if (cnt == CntLast) begin
            state        <= NEXT;
            glyph_enable <= 1'b0;
            plot         <= 1'b0;
          end
        end

        NEXT: begin
          if (slot == 4'd15) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= FETCH;
            slot  <= slot + 4'd1;
          end
        end

        DONE: begin
          // A start that arrives here is dropped on purpose; it is not queued.
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state        <= IDLE;
          glyph_enable <= 1'b0;
          glyph_resetn <= 1'b1;
          plot         <= 1'b0;
          busy         <= 1'b0;
          done         <= 1'b0;
        end
      endcase
    end
  end

endmodule
